// File: rtl/multi_wait_sequencer.sv
// Stage sequencer: each run steps through NUM_WAITS stages, emitting base+stage and then idling len cycles.
// A done pulse closes each run; loop_mode restarts immediately from stage 0 with the latched base and len.
module multi_wait_sequencer #(
    parameter int WIDTH     = 32,
    parameter int NUM_WAITS = 4,
    parameter int CNT_WIDTH = 8,
    localparam int STAGE_W  = (NUM_WAITS > 1) ? $clog2(NUM_WAITS) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic signed [WIDTH-1:0] in1,
    input  logic [CNT_WIDTH-1:0]    wait_len,
    input  logic                    start,
    input  logic                    abort,
    input  logic                    loop_mode,
    output logic signed [WIDTH-1:0] out1,
    output logic [STAGE_W-1:0]      stage_idx,
    output logic                    busy,
    output logic                    done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(NUM_WAITS - 1);

    logic [1:0]              r_state;
    logic [1:0]              w_next_state;
    logic signed [WIDTH-1:0] r_base;
    logic [CNT_WIDTH-1:0]    r_len;
    logic [CNT_WIDTH-1:0]    r_counter;
    logic [STAGE_W-1:0]      r_stage;
    logic signed [WIDTH-1:0] r_out;
    logic [WIDTH-1:0]        w_sum;
    logic                    w_last_wait;

    assign w_sum       = WIDTH'(r_base) + WIDTH'(r_stage);
    assign w_last_wait = (r_counter == CNT_WIDTH'(1));

    // Abort overrides every transition, so it is applied after the normal decode.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (start) w_next_state = S_EXEC;
            S_EXEC: w_next_state = S_WAIT;
            S_WAIT: begin
                if (w_last_wait)
                    w_next_state = (r_stage == LAST_STAGE) ? S_DONE : S_EXEC;
            end
            S_DONE: w_next_state = loop_mode ? S_EXEC : S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
        if (abort)
            w_next_state = S_IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_base    <= '0;
            r_len     <= CNT_WIDTH'(1);
            r_counter <= '0;
            r_stage   <= '0;
            r_out     <= '0;
        end else begin
            r_state <= w_next_state;
            if (abort) begin
                r_stage <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            r_base  <= in1;
                            r_len   <= (wait_len == '0) ? CNT_WIDTH'(1) : wait_len;
                            r_stage <= '0;
                        end
                    end
                    S_EXEC: begin
                        r_out     <= signed'(w_sum);
                        r_counter <= r_len;
                    end
                    S_WAIT: begin
                        r_counter <= r_counter - CNT_WIDTH'(1);
                        if (w_last_wait && (r_stage != LAST_STAGE))
                            r_stage <= r_stage + STAGE_W'(1);
                    end
                    S_DONE: r_stage <= '0;
                    default: r_stage <= '0;
                endcase
            end
        end
    end

    assign out1      = r_out;
    assign stage_idx = r_stage;
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);

endmodule

// File: tb/tb_multi_wait_sequencer.sv
// Directed self-checking bench for multi_wait_sequencer (WIDTH=8, NUM_WAITS=4).
// Cycle c is the interval after the (c-1)th edge counted from the edge that accepts start.
module tb_multi_wait_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in1;
    logic [7:0] waitLen;
    logic       start;
    logic       abort;
    logic       loopMode;
    logic [7:0] out1;
    logic [1:0] stageIdx;
    logic       busy;
    logic       done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    multi_wait_sequencer #(
        .WIDTH    (8),
        .NUM_WAITS(4),
        .CNT_WIDTH(8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in1      (in1),
        .wait_len (waitLen),
        .start    (start),
        .abort    (abort),
        .loop_mode(loopMode),
        .out1     (out1),
        .stage_idx(stageIdx),
        .busy     (busy),
        .done     (done)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] base, input logic [7:0] len,
                                 input logic st, input logic ab, input logic lp);
        in1      = base;
        waitLen  = len;
        start    = st;
        abort    = ab;
        loopMode = lp;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Expected waveform of one non-looping run: stage period p = len+1, run spans 4p+1 cycles.
    task automatic runNormal(input string tag, input logic [7:0] base, input logic [7:0] len);
        int p;
        int runCycles;
        int k;
        logic [7:0] expOut;
        p = ((len == 8'd0) ? 1 : int'(len)) + 1;
        runCycles = 4 * p + 1;
        applyStimulus(base, len, 1'b1, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(8'h55, 8'd7, 1'b0, 1'b0, 1'b0);
        for (int c = 1; c <= runCycles + 1; c++) begin
            checkOutput($sformatf("%s busy c%0d", tag, c), 64'(busy), 64'(c <= runCycles));
            checkOutput($sformatf("%s done c%0d", tag, c), 64'(done), 64'(c == runCycles));
            if (c >= 2) begin
                k = (c - 2) / p;
                if (k > 3) k = 3;
                expOut = base + 8'(k);
                checkOutput($sformatf("%s out1 c%0d", tag, c), 64'(out1), 64'(expOut));
            end
            if (c <= runCycles) begin
                k = (c - 1) / p;
                if (k > 3) k = 3;
                checkOutput($sformatf("%s stage c%0d", tag, c), 64'(stageIdx), 64'(k));
                nextCycle();
            end
        end
    endtask

    initial begin
        logic sawDone;
        logic sawBusy;

        reset = 1'b0;
        applyStimulus(8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("rst out1", 64'(out1), 64'd0);
        checkOutput("rst busy", 64'(busy), 64'd0);
        checkOutput("rst done", 64'(done), 64'd0);
        checkOutput("rst stage", 64'(stageIdx), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;

        $display("[TB] basic run, wait_len=3");
        runNormal("len3", 8'd10, 8'd3);

        $display("[TB] wait_len=0 and wait_len=1");
        runNormal("len0", 8'd20, 8'd0);
        runNormal("len1", 8'd20, 8'd1);

        $display("[TB] signed wrap 7E..81");
        runNormal("wrap", 8'h7E, 8'd2);

        $display("[TB] abort in second WAIT");
        applyStimulus(8'd10, 8'd3, 1'b1, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(8'd10, 8'd3, 1'b0, 1'b0, 1'b0);
        repeat (6) nextCycle();
        checkOutput("preAbort out1", 64'(out1), 64'd11);
        checkOutput("preAbort stage", 64'(stageIdx), 64'd1);
        applyStimulus(8'd10, 8'd3, 1'b0, 1'b1, 1'b0);
        nextCycle();
        checkOutput("abort busy", 64'(busy), 64'd0);
        checkOutput("abort done", 64'(done), 64'd0);
        checkOutput("abort out1", 64'(out1), 64'd11);
        checkOutput("abort stage", 64'(stageIdx), 64'd0);
        applyStimulus(8'd10, 8'd3, 1'b1, 1'b1, 1'b0);
        nextCycle();
        checkOutput("abortStart busy", 64'(busy), 64'd0);
        checkOutput("abortStart done", 64'(done), 64'd0);
        runNormal("afterAbort", 8'd10, 8'd3);

        $display("[TB] loop mode");
        applyStimulus(8'd5, 8'd1, 1'b1, 1'b0, 1'b1);
        nextCycle();
        applyStimulus(8'd5, 8'd1, 1'b0, 1'b0, 1'b1);
        repeat (2) nextCycle();
        applyStimulus(8'd100, 8'd9, 1'b1, 1'b0, 1'b1);
        nextCycle();
        applyStimulus(8'd100, 8'd9, 1'b0, 1'b0, 1'b1);
        repeat (2) nextCycle();
        checkOutput("loop out1 c6", 64'(out1), 64'd7);
        repeat (3) nextCycle();
        checkOutput("loop done c9", 64'(done), 64'd1);
        checkOutput("loop out1 c9", 64'(out1), 64'd8);
        nextCycle();
        checkOutput("loop busy c10", 64'(busy), 64'd1);
        checkOutput("loop done c10", 64'(done), 64'd0);
        checkOutput("loop stage c10", 64'(stageIdx), 64'd0);
        nextCycle();
        checkOutput("loop out1 c11", 64'(out1), 64'd5);
        repeat (7) nextCycle();
        checkOutput("loop done c18", 64'(done), 64'd1);
        applyStimulus(8'd100, 8'd9, 1'b0, 1'b1, 1'b1);
        nextCycle();
        checkOutput("loopAbort busy", 64'(busy), 64'd0);
        checkOutput("loopAbort done", 64'(done), 64'd0);
        checkOutput("loopAbort stage", 64'(stageIdx), 64'd0);
        checkOutput("loopAbort out1", 64'(out1), 64'd8);
        applyStimulus(8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
        nextCycle();
        checkOutput("loopAbort idle", 64'(busy), 64'd0);

        $display("[TB] async reset mid-WAIT");
        applyStimulus(8'd10, 8'd3, 1'b1, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(8'd10, 8'd3, 1'b0, 1'b0, 1'b0);
        repeat (2) nextCycle();
        checkOutput("preReset out1", 64'(out1), 64'd10);
        checkOutput("preReset busy", 64'(busy), 64'd1);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("asyncRst out1", 64'(out1), 64'd0);
        checkOutput("asyncRst busy", 64'(busy), 64'd0);
        checkOutput("asyncRst done", 64'(done), 64'd0);
        checkOutput("asyncRst stage", 64'(stageIdx), 64'd0);
        repeat (2) nextCycle();
        checkOutput("heldRst busy", 64'(busy), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        sawDone = 1'b0;
        sawBusy = 1'b0;
        repeat (30) begin
            nextCycle();
            if (done) sawDone = 1'b1;
            if (busy) sawBusy = 1'b1;
        end
        checkOutput("postRst done", 64'(sawDone), 64'd0);
        checkOutput("postRst busy", 64'(sawBusy), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multi_wait_sequencer.md
MULTI_WAIT_SEQUENCER -- requirements
Module: multi_wait_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, setting the data width of in1 and out1.
REQ-002 The block SHALL have parameter NUM_WAITS, default 4, setting the number of stages per run, legal range 1..256.
REQ-003 The block SHALL have parameter CNT_WIDTH, default 8, setting the width of the wait-length input and the internal wait counter.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit, asynchronous active-low reset: low clears state immediately, independent of clk.
REQ-006 The block SHALL have port in1, input, signed WIDTH bits, the base value sampled at start.
REQ-007 The block SHALL have port wait_len, input, CNT_WIDTH bits, the per-stage wait length in cycles, sampled at start.
REQ-008 The block SHALL have port start, input, 1 bit, the run request, accepted only in IDLE.
REQ-009 The block SHALL have port abort, input, 1 bit, a synchronous cancel of the current run.
REQ-010 The block SHALL have port loop_mode, input, 1 bit: when 1, a run restarts at stage 0 after DONE instead of returning to IDLE.
REQ-011 The block SHALL have port out1, output, signed WIDTH bits, the registered stage value.
REQ-012 The block SHALL have port stage_idx, output, max(1,clog2(NUM_WAITS)) bits, the current stage number.
REQ-013 The block SHALL have port busy, output, 1 bit, high in every state other than IDLE.
REQ-014 The block SHALL have port done, output, 1 bit, a one-cycle pulse in state DONE.

Function
REQ-015 The block SHALL implement the four-state FSM IDLE, EXEC, WAIT, DONE, with registered current state, next-state logic and no latches.
REQ-016 In IDLE, when start=1 and abort=0, the block SHALL latch base=in1, len=(wait_len==0 ? 1 : wait_len) and stage=0, and go to EXEC.
REQ-017 EXEC SHALL last exactly one cycle, load out1<=base+stage and counter<=len, and go to WAIT.
REQ-018 WAIT SHALL last exactly len cycles, decrementing counter each cycle; on the cycle counter==1 it SHALL go to DONE if stage==NUM_WAITS-1, else stage<=stage+1 and go to EXEC.
REQ-019 DONE SHALL last one cycle with done=1, then go to EXEC with stage<=0 (base and len kept) if loop_mode=1, else to IDLE.
REQ-020 Stage period SHALL be len+1 cycles; a non-looping run SHALL occupy NUM_WAITS*(len+1)+1 cycles from the first EXEC through DONE.
REQ-021 base+stage SHALL wrap modulo 2^WIDTH; no saturation, no overflow flag.
REQ-022 A start asserted while busy=1 SHALL be ignored, not queued.
REQ-023 abort=1 in any non-IDLE state SHALL force IDLE at the next edge, with done not pulsed, out1 holding its value and stage<=0.
REQ-024 abort=1 and start=1 together in IDLE SHALL leave the block in IDLE.
REQ-025 abort SHALL take priority over every other transition, including the DONE-to-EXEC loop transition.
REQ-026 in1 and wait_len changes after start SHALL not affect the run in progress, including loop iterations.
REQ-027 stage_idx SHALL equal the internal stage register at all times.

Reset
REQ-028 While reset=0 the block SHALL hold state=IDLE, out1=0, stage_idx=0, busy=0, done=0, counter=0, base=0 and len=1.
REQ-029 Reset assertion mid-run SHALL abandon the run with no done pulse; after reset rises, the block SHALL wait in IDLE for a new start.

Verification
REQ-030 Bench SHALL check: NUM_WAITS=4, in1=10, wait_len=3, start one cycle at edge 0 -> EXEC at cycles 1,5,9,13; out1=10,11,12,13 from cycles 2,6,10,14; done=1 at cycle 17 only; busy=0 from cycle 18.
REQ-031 Bench SHALL check: wait_len=0 -> each stage period 2 cycles, identical to wait_len=1.
REQ-032 Bench SHALL check: WIDTH=8, in1=8'sh7E, NUM_WAITS=4 -> out1 sequence 7E,7F,80,81.
REQ-033 Bench SHALL check: abort=1 during the second WAIT -> IDLE next edge, done stays 0, out1=11 held, stage_idx=0; a following start runs normally.
REQ-034 Bench SHALL check: loop_mode=1 -> after done pulse, out1 returns to base in the next EXEC with no IDLE cycle; start pulses during the run have no effect.
REQ-035 Bench SHALL check: reset=0 asynchronously mid-WAIT -> all outputs 0 without a clk edge; no done after reset is released.
